// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I(+M) decode stage with output pipeline register and hazard interlocks
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid_i / in_ready_o          instruction handshake from IF/ID
//   inst_i, inst_addr_i              instruction and its address
//   reg1/2_r_addr_o, reg1/2_r_data_i register-file read port (address combinational from inst_i)
//   ex_jump_ena_i                    taken jump/branch in EX, flushes this stage
//   ex_ready_i / out_valid_o         output register handshake towards EX
//   inst_o .. illegal_o              registered decode results

module id_stage #(
  parameter int XLEN       = 32,
  parameter int REG_NUM    = 32,
  parameter int M_EXT      = 1,
  parameter int DIV_CYCLES = 33,
  localparam int REG_AW    = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  output logic [REG_AW-1:0] reg1_r_addr_o,
  output logic [REG_AW-1:0] reg2_r_addr_o,
  input  logic [XLEN-1:0]   reg1_r_data_i,
  input  logic [XLEN-1:0]   reg2_r_data_i,
  input  logic              ex_jump_ena_i,
  input  logic              ex_ready_i,
  output logic              out_valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_addr_o,
  output logic [XLEN-1:0]   reg1_r_data_o,
  output logic [XLEN-1:0]   reg2_r_data_o,
  output logic              reg_w_ena_o,
  output logic [REG_AW-1:0] reg_w_addr_o,
  output logic              mem_r_ena_o,
  output logic              mem_w_ena_o,
  output logic              div_o,
  output logic              illegal_o
);

  localparam int DIV_CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_funct7;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_funct3 = inst_i[14:12];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];
  assign w_funct7 = inst_i[31:25];

  logic w_use_rs1, w_use_rs2, w_use_rd;
  logic w_mem_r, w_mem_w, w_is_div, w_known;

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_mem_r   = 1'b0;
    w_mem_w   = 1'b0;
    w_is_div  = 1'b0;
    w_known   = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
        case (w_funct7)
          F7_BASE: w_known = 1'b1;
          F7_ALT:  w_known = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
          F7_MUL: begin
            w_known  = (M_EXT != 0);
            w_is_div = w_funct3[2];
          end
          default: w_known = 1'b0;
        endcase
      end
      OP_IMM: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        case (w_funct3)
          3'b001:  w_known = (w_funct7 == F7_BASE);
          3'b101:  w_known = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
          default: w_known = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_mem_r   = 1'b1;
        w_known   = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                    (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_mem_w   = 1'b1;
        w_known   = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
      end
      OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_known   = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
      end
      OP_JAL: begin
        w_use_rd = 1'b1;
        w_known  = 1'b1;
      end
      OP_JALR: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_known   = (w_funct3 == 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        w_use_rd = 1'b1;
        w_known  = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  // Register indices beyond REG_NUM (RV32E) are only illegal where the field is actually used.
  logic w_range_bad;
  logic w_illegal;
  assign w_range_bad = (w_use_rs1 && (32'(w_rs1) >= 32'(REG_NUM))) ||
                       (w_use_rs2 && (32'(w_rs2) >= 32'(REG_NUM))) ||
                       (w_use_rd  && (32'(w_rd)  >= 32'(REG_NUM)));
  assign w_illegal   = !w_known || w_range_bad;

  assign reg1_r_addr_o = (w_use_rs1 && !w_illegal) ? w_rs1[REG_AW-1:0] : '0;
  assign reg2_r_addr_o = (w_use_rs2 && !w_illegal) ? w_rs2[REG_AW-1:0] : '0;

  logic              w_reg_w;
  logic [REG_AW-1:0] w_reg_w_addr;
  assign w_reg_w      = w_use_rd && !w_illegal && (w_rd != 5'd0);
  assign w_reg_w_addr = w_reg_w ? w_rd[REG_AW-1:0] : '0;

  logic              r_valid;
  logic [31:0]       r_inst;
  logic [31:0]       r_inst_addr;
  logic [XLEN-1:0]   r_reg1_data;
  logic [XLEN-1:0]   r_reg2_data;
  logic              r_reg_w;
  logic [REG_AW-1:0] r_reg_w_addr;
  logic              r_mem_r;
  logic              r_mem_w;
  logic              r_div;
  logic              r_illegal;
  logic [DIV_CW-1:0] r_div_cnt;

  // Compare against the raw 5-bit rs fields so an out-of-range index never aliases a low register.
  logic w_load_use;
  logic w_div_busy;
  logic w_stall;
  logic w_advance;
  logic w_capture;
  assign w_load_use = r_valid && r_mem_r && (r_reg_w_addr != '0) &&
                      ((w_use_rs1 && (w_rs1 == 5'(r_reg_w_addr))) ||
                       (w_use_rs2 && (w_rs2 == 5'(r_reg_w_addr))));
  assign w_div_busy = (r_div_cnt != '0);
  assign w_stall    = w_load_use || w_div_busy;
  assign w_advance  = !r_valid || ex_ready_i;
  assign w_capture  = !ex_jump_ena_i && w_advance && !w_stall && in_valid_i;

  // During a flush the presented instruction is swallowed, so the stage always reports ready.
  assign in_ready_o = ex_jump_ena_i || (w_advance && !w_stall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_inst       <= '0;
      r_inst_addr  <= '0;
      r_reg1_data  <= '0;
      r_reg2_data  <= '0;
      r_reg_w      <= 1'b0;
      r_reg_w_addr <= '0;
      r_mem_r      <= 1'b0;
      r_mem_w      <= 1'b0;
      r_div        <= 1'b0;
      r_illegal    <= 1'b0;
      r_div_cnt    <= '0;
    end else begin
      if (w_capture) begin
        r_valid      <= 1'b1;
        r_inst       <= inst_i;
        r_inst_addr  <= inst_addr_i;
        r_reg1_data  <= reg1_r_data_i;
        r_reg2_data  <= reg2_r_data_i;
        r_reg_w      <= w_reg_w;
        r_reg_w_addr <= w_reg_w_addr;
        r_mem_r      <= w_mem_r && !w_illegal;
        r_mem_w      <= w_mem_w && !w_illegal;
        r_div        <= w_is_div && !w_illegal;
        r_illegal    <= w_illegal;
      end else if (ex_jump_ena_i || w_advance) begin
        r_valid      <= 1'b0;
        r_inst       <= '0;
        r_inst_addr  <= '0;
        r_reg1_data  <= '0;
        r_reg2_data  <= '0;
        r_reg_w      <= 1'b0;
        r_reg_w_addr <= '0;
        r_mem_r      <= 1'b0;
        r_mem_w      <= 1'b0;
        r_div        <= 1'b0;
        r_illegal    <= 1'b0;
      end

      // The divider keeps running across a flush; only reset clears the count.
      if (w_capture && w_is_div && !w_illegal) begin
        r_div_cnt <= DIV_CW'(DIV_CYCLES - 1);
      end else if (w_div_busy) begin
        r_div_cnt <= r_div_cnt - 1'b1;
      end
    end
  end

  assign out_valid_o   = r_valid;
  assign inst_o        = r_inst;
  assign inst_addr_o   = r_inst_addr;
  assign reg1_r_data_o = r_reg1_data;
  assign reg2_r_data_o = r_reg2_data;
  assign reg_w_ena_o   = r_reg_w;
  assign reg_w_addr_o  = r_reg_w_addr;
  assign mem_r_ena_o   = r_mem_r;
  assign mem_w_ena_o   = r_mem_w;
  assign div_o         = r_div;
  assign illegal_o     = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage

module tb_id_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a: default parameters (RV32IM, DIV_CYCLES = 33)
  logic        a_in_valid, a_in_ready, a_jump, a_ex_ready;
  logic [31:0] a_inst, a_inst_addr;
  logic [4:0]  a_r1a, a_r2a, a_wa;
  logic [31:0] a_r1d, a_r2d, a_r1q, a_r2q, a_inst_q, a_addr_q;
  logic        a_valid, a_we, a_mr, a_mw, a_div, a_ill;

  assign a_r1d = 32'h100 + 32'(a_r1a);
  assign a_r2d = 32'h100 + 32'(a_r2a);

  id_stage dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .inst_i(a_inst), .inst_addr_i(a_inst_addr),
    .reg1_r_addr_o(a_r1a), .reg2_r_addr_o(a_r2a),
    .reg1_r_data_i(a_r1d), .reg2_r_data_i(a_r2d),
    .ex_jump_ena_i(a_jump), .ex_ready_i(a_ex_ready),
    .out_valid_o(a_valid), .inst_o(a_inst_q), .inst_addr_o(a_addr_q),
    .reg1_r_data_o(a_r1q), .reg2_r_data_o(a_r2q),
    .reg_w_ena_o(a_we), .reg_w_addr_o(a_wa),
    .mem_r_ena_o(a_mr), .mem_w_ena_o(a_mw),
    .div_o(a_div), .illegal_o(a_ill)
  );

  // Instance b: RV32E without M
  logic        b_in_valid, b_in_ready, b_jump, b_ex_ready;
  logic [31:0] b_inst, b_inst_addr;
  logic [3:0]  b_r1a, b_r2a, b_wa;
  logic [31:0] b_r1d, b_r2d, b_r1q, b_r2q, b_inst_q, b_addr_q;
  logic        b_valid, b_we, b_mr, b_mw, b_div, b_ill;

  assign b_r1d = 32'h200 + 32'(b_r1a);
  assign b_r2d = 32'h200 + 32'(b_r2a);

  id_stage #(.XLEN(32), .REG_NUM(16), .M_EXT(0), .DIV_CYCLES(33)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .inst_i(b_inst), .inst_addr_i(b_inst_addr),
    .reg1_r_addr_o(b_r1a), .reg2_r_addr_o(b_r2a),
    .reg1_r_data_i(b_r1d), .reg2_r_data_i(b_r2d),
    .ex_jump_ena_i(b_jump), .ex_ready_i(b_ex_ready),
    .out_valid_o(b_valid), .inst_o(b_inst_q), .inst_addr_o(b_addr_q),
    .reg1_r_data_o(b_r1q), .reg2_r_data_o(b_r2q),
    .reg_w_ena_o(b_we), .reg_w_addr_o(b_wa),
    .mem_r_ena_o(b_mr), .mem_w_ena_o(b_mw),
    .div_o(b_div), .illegal_o(b_ill)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [31:0] I_ADD_1_2_3  = {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] I_ADDI_4_1_5 = {12'd5, 5'd1, 3'b000, 5'd4, 7'b0010011};
  localparam logic [31:0] I_LW_5_1     = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] I_ADD_6_5_7  = {7'b0000000, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] I_LW_0_1     = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] I_ADD_6_0_7  = {7'b0000000, 5'd7, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] I_DIV_8_9_10 = {7'b0000001, 5'd10, 5'd9, 3'b100, 5'd8, 7'b0110011};
  localparam logic [31:0] I_SW_7_8_1   = {7'b0000000, 5'd7, 5'd1, 3'b010, 5'd8, 7'b0100011};
  localparam logic [31:0] I_ADD_17_1_2 = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd17, 7'b0110011};

  initial begin
    int cnt;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_inst = '0; a_inst_addr = '0; a_jump = 1'b0; a_ex_ready = 1'b1;
    b_in_valid = 1'b0; b_inst = '0; b_inst_addr = '0; b_jump = 1'b0; b_ex_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("reset_valid", 64'(a_valid), 64'd0);
    chk("reset_inst", 64'(a_inst_q), 64'd0);
    chk("reset_we", 64'(a_we), 64'd0);
    chk("reset_ready", 64'(a_in_ready), 64'd1);

    // Back-to-back ADD / ADDI
    a_in_valid = 1'b1; a_inst = I_ADD_1_2_3; a_inst_addr = 32'h1000;
    settle();
    chk("add_r1a", 64'(a_r1a), 64'd2);
    chk("add_r2a", 64'(a_r2a), 64'd3);
    tick();
    chk("add_valid", 64'(a_valid), 64'd1);
    chk("add_wa", 64'(a_wa), 64'd1);
    chk("add_r2q", 64'(a_r2q), 64'h103);
    chk("add_addr", 64'(a_addr_q), 64'h1000);
    a_inst = I_ADDI_4_1_5; a_inst_addr = 32'h1004;
    settle();
    chk("addi_r1a", 64'(a_r1a), 64'd1);
    chk("addi_r2a", 64'(a_r2a), 64'd0);
    chk("addi_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("addi_valid", 64'(a_valid), 64'd1);
    chk("addi_inst", 64'(a_inst_q), 64'(I_ADDI_4_1_5));
    chk("addi_wa", 64'(a_wa), 64'd4);
    chk("addi_r1q", 64'(a_r1q), 64'h101);

    // Load-use: exactly one bubble
    a_inst = I_LW_5_1;
    tick();
    chk("lw_mr", 64'(a_mr), 64'd1);
    chk("lw_we", 64'(a_we), 64'd1);
    a_inst = I_ADD_6_5_7;
    settle();
    chk("lu_ready", 64'(a_in_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(a_valid), 64'd0);
    settle();
    chk("lu_ready_after", 64'(a_in_ready), 64'd1);
    tick();
    chk("lu_issue_valid", 64'(a_valid), 64'd1);
    chk("lu_issue_inst", 64'(a_inst_q), 64'(I_ADD_6_5_7));

    // Load to x0 creates no hazard
    a_inst = I_LW_0_1;
    tick();
    chk("lw0_we", 64'(a_we), 64'd0);
    a_inst = I_ADD_6_0_7;
    settle();
    chk("lw0_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("lw0_next_valid", 64'(a_valid), 64'd1);
    chk("lw0_next_inst", 64'(a_inst_q), 64'(I_ADD_6_0_7));

    // Divide blocks the following ADD for 32 cycles
    a_inst = I_DIV_8_9_10;
    tick();
    chk("div_flag", 64'(a_div), 64'd1);
    chk("div_wa", 64'(a_wa), 64'd8);
    a_inst = I_ADD_1_2_3;
    settle();
    chk("div_busy_ready", 64'(a_in_ready), 64'd0);
    cnt = 0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (a_valid) break;
    end
    chk("div_gap", 64'(cnt), 64'd33);
    chk("div_next_inst", 64'(a_inst_q), 64'(I_ADD_1_2_3));

    // Back-pressure with a store pending
    a_inst = I_SW_7_8_1;
    tick();
    a_ex_ready = 1'b0;
    a_inst = I_ADDI_4_1_5;
    settle();
    chk("bp_ready", 64'(a_in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 64'(a_valid), 64'd1);
      chk("bp_inst", 64'(a_inst_q), 64'(I_SW_7_8_1));
      chk("bp_mw", 64'(a_mw), 64'd1);
      chk("bp_mr", 64'(a_mr), 64'd0);
      chk("bp_we", 64'(a_we), 64'd0);
    end
    a_ex_ready = 1'b1;
    settle();
    chk("bp_release_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("bp_release_inst", 64'(a_inst_q), 64'(I_ADDI_4_1_5));

    // Flush during a load-use stall
    a_inst = I_LW_5_1;
    tick();
    a_inst = I_ADD_6_5_7;
    settle();
    chk("fl_stall_ready", 64'(a_in_ready), 64'd0);
    a_jump = 1'b1;
    settle();
    chk("fl_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("fl_valid", 64'(a_valid), 64'd0);
    a_jump = 1'b0;
    a_in_valid = 1'b0;
    tick();
    chk("fl_discarded", 64'(a_valid), 64'd0);

    // Unknown opcode
    a_in_valid = 1'b1;
    a_inst = 32'hFFFF_FFFF;
    tick();
    chk("ill_flag", 64'(a_ill), 64'd1);
    chk("ill_we", 64'(a_we), 64'd0);
    chk("ill_inst", 64'(a_inst_q), 64'hFFFF_FFFF);

    // RV32E without M: DIV illegal and non-blocking, x17 illegal
    b_in_valid = 1'b1;
    b_inst = I_DIV_8_9_10;
    tick();
    chk("bdiv_valid", 64'(b_valid), 64'd1);
    chk("bdiv_ill", 64'(b_ill), 64'd1);
    chk("bdiv_div", 64'(b_div), 64'd0);
    chk("bdiv_we", 64'(b_we), 64'd0);
    chk("bdiv_wa", 64'(b_wa), 64'd0);
    chk("bdiv_inst", 64'(b_inst_q), 64'(I_DIV_8_9_10));
    b_inst = I_ADD_1_2_3;
    settle();
    chk("bdiv_no_busy", 64'(b_in_ready), 64'd1);
    tick();
    chk("badd_ill", 64'(b_ill), 64'd0);
    chk("badd_wa", 64'(b_wa), 64'd1);
    b_inst = I_ADD_17_1_2;
    tick();
    chk("bx17_ill", 64'(b_ill), 64'd1);
    chk("bx17_we", 64'(b_we), 64'd0);
    b_in_valid = 1'b0;

    // Reset in the middle of a divide
    a_inst = I_DIV_8_9_10;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_div_valid", 64'(a_valid), 64'd0);
    chk("rst_div_flag", 64'(a_div), 64'd0);
    a_in_valid = 1'b1;
    a_inst = I_ADD_1_2_3;
    settle();
    chk("rst_div_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("rst_div_accept", 64'(a_valid), 64'd1);
    a_in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Registered, parametrised decode stage for the RISC_V_PIPE core, sitting between the IF/ID register and EX. It decodes RV32I and, optionally, the M extension, and drives register-file read addresses combinationally. Decoded control and operands are captured into an output pipeline register with a valid/ready handshake. It also owns the load-use interlock, the multi-cycle divider structural interlock, and flush on a taken jump from EX.

## Interface
Parameters:
- XLEN, 32, data width of register operands
- REG_NUM, 32, architectural registers (32 = RV32I, 16 = RV32E); REG_AW = $clog2(REG_NUM) address bits
- M_EXT, 1, 1 decodes MUL/DIV group (funct7 = 0000001), 0 treats it as illegal
- DIV_CYCLES, 33, cycles the EX divider is busy after a DIV/DIVU/REM/REMU issue (>= 2)

Ports (clock/reset: one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  IF/ID holds a valid instruction
- in_ready_o  out  1  stage accepts inst_i this cycle
- inst_i  in  32  instruction
- inst_addr_i  in  32  instruction address
- reg1_r_addr_o  out  REG_AW  rs1 read address (combinational from inst_i)
- reg2_r_addr_o  out  REG_AW  rs2 read address (combinational from inst_i)
- reg1_r_data_i  in  XLEN  register file read data 1
- reg2_r_data_i  in  XLEN  register file read data 2
- ex_jump_ena_i  in  1  EX taken jump/branch: flush
- ex_ready_i  in  1  EX accepts the output register this cycle
- out_valid_o  out  1  output register valid
- inst_o, inst_addr_o  out  32  registered instruction / address
- reg1_r_data_o, reg2_r_data_o  out  XLEN  registered operands
- reg_w_ena_o  out  1  write rd
- reg_w_addr_o  out  REG_AW  rd
- mem_r_ena_o, mem_w_ena_o  out  1  load / store
- div_o  out  1  instruction is a divide (starts EX divider)
- illegal_o  out  1  instruction failed decode

## Operation
- Decoded classes: R (ADD..AND with funct7 0000000/0100000; MUL group if M_EXT), OP-IMM, LOAD (LB/LH/LW/LBU/LHU), STORE (SB/SH/SW), BRANCH (6), JAL, JALR, LUI, AUIPC.
- Unused rs fields drive address 0. Store: mem_w=1, mem_r=0, reg_w=0. Load: mem_r=1, reg_w=1. Branch: no writes.
- reg_w_ena forced 0 when rd == 0.
- Illegal: unknown opcode/funct3/funct7, M group with M_EXT=0, or any used rs/rd index >= REG_NUM. Captured as NOP (all enables 0, addresses 0) with illegal_o=1; inst_o/inst_addr_o still carry the raw values.
- advance = !out_valid_o | ex_ready_i.
- load_use = out_valid_o & mem_r_ena_o & reg_w_addr_o != 0 & (reg_w_addr_o matches a used rs of inst_i).
- div_busy = div_cnt != 0. div_cnt loads DIV_CYCLES-1 when a div is captured and decrements to 0. While busy, any instruction stalls.
- stall = load_use | div_busy.
- in_ready_o = advance & !stall, or 1 during flush.
- On advance: output register loads the decode of inst_i if in_valid_i & in_ready_o; otherwise it loads a bubble (out_valid_o=0).
- Flush (ex_jump_ena_i=1): out_valid_o <= 0, and any presented instruction is consumed and discarded. Flush dominates stall and the handshake. div_cnt is not cleared, because the divide is already in EX.

## Timing
- Reset (rst_n=0 at clk edge): out_valid_o=0, all registered outputs 0, div_cnt=0. in_ready_o=1 after reset.
- Latency: accept at edge N -> out_valid_o=1 after edge N. Throughput is 1 instruction/cycle without hazards.
- Operands are sampled in the accept cycle.
- Load-use costs exactly one bubble once EX accepts the load.
- A divide blocks the next instruction for DIV_CYCLES-1 cycles after capture.
- ex_ready_i=0 with out_valid_o=1: all outputs held stable; in_ready_o=0.
- Reset mid-stall or mid-divide: the state clears in one cycle.

## Test plan
- Back-to-back ADD x1,x2,x3; ADDI x4,x1,5 with ex_ready_i=1 -> two consecutive out_valid cycles; second has reg1_r_addr_o=1, reg_w_addr_o=4, reg2 addr 0.
- LW x5,0(x1) then ADD x6,x5,x7 -> in_ready_o=0 one cycle, one out_valid_o=0 bubble, then ADD issues; ADD x6,x0,x7 after LW x0 -> no bubble.
- DIV x8,x9,x10 (DIV_CYCLES=33) followed by ADD -> div_o=1, ADD out_valid exactly 33 cycles after DIV's; with M_EXT=0 DIV -> illegal_o=1, NOP, no busy.
- ex_ready_i held 0 for 3 cycles with SW pending -> outputs stable, mem_w=1, mem_r=0, in_ready_o=0; release -> next instruction follows.
- ex_jump_ena_i=1 during load-use stall -> in_ready_o=1, out_valid_o=0 next cycle, instruction discarded.
- REG_NUM=16: ADD x17,x1,x2 -> illegal_o=1, reg_w_ena_o=0; rst_n=0 mid-divide -> out_valid_o=0, next ADD accepted immediately.
